// File: rtl/apb_ctrl_pkg.sv
// apb_ctrl_pkg: shared widths and FSM state encoding for the arbitrated APB master
package apb_ctrl_pkg;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int NUM_REQ = 2;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: 2-way round-robin arbiter; on a tie the requester not granted last wins
module rr_arbiter
    import apb_ctrl_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last_grant,
    output logic [NUM_REQ-1:0] grant
);
    always_comb grant = (&req) ? (last_grant ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/apb_arb_master.sv
// apb_arb_master: two requesters share one APB master port via round-robin arbitration
module apb_arb_master
    import apb_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                           pclk,
    input  logic                           preset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]             resp_done,
    output logic [DATA_W-1:0]              resp_rdata,
    output logic                           resp_err,
    output logic                           busy,
    output logic                           psel,
    output logic                           penable,
    output logic                           pwrite,
    output logic [ADDR_W-1:0]              paddr,
    output logic [DATA_W-1:0]              pwdata,
    input  logic [DATA_W-1:0]              prdata,
    input  logic                           pready,
    input  logic                           pslverr
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_e              state_q;
    logic [NUM_REQ-1:0]  grant;
    logic                gnt_idx;
    logic                gnt_q;
    logic                last_grant_q;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       cnt_d;
    logic [NUM_REQ-1:0]  resp_done_q;
    logic [DATA_W-1:0]   resp_rdata_q;
    logic                resp_err_q;
    logic                busy_q;
    logic                psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;

    rr_arbiter u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign gnt_idx = grant[1];
    assign cnt_d   = cnt_q + 1'b1;

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state_q      <= IDLE;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            resp_done_q  <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
        end else begin
            resp_done_q <= '0;
            unique case (state_q)
                IDLE: if (|req_valid) begin
                    state_q      <= SETUP;
                    busy_q       <= 1'b1;
                    psel_q       <= 1'b1;
                    gnt_q        <= gnt_idx;
                    last_grant_q <= gnt_idx;
                    cnt_q        <= '0;
                    pwrite_q     <= req_write[gnt_idx];
                    paddr_q      <= req_addr[gnt_idx];
                    pwdata_q     <= req_write[gnt_idx] ? req_wdata[gnt_idx] : '0;
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                end
                ACCESS: if (pready || cnt_d == CW'(TIMEOUT)) begin
                    // a late pready on the final wait cycle still completes normally
                    state_q      <= DONE;
                    psel_q       <= 1'b0;
                    penable_q    <= 1'b0;
                    resp_done_q  <= gnt_q ? 2'b10 : 2'b01;
                    resp_rdata_q <= (pready && !pwrite_q) ? prdata : '0;
                    resp_err_q   <= pready ? pslverr : 1'b1;
                end else begin
                    cnt_q <= cnt_d;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign resp_done  = resp_done_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign busy       = busy_q;
    assign psel       = psel_q;
    assign penable    = penable_q;
    assign pwrite     = pwrite_q;
    assign paddr      = paddr_q;
    assign pwdata     = pwdata_q;
endmodule

// File: tb/tb_apb_arb_master.sv
// tb_apb_arb_master: directed stimulus with a response scoreboard checked by an independent monitor
module tb_apb_arb_master;
    logic             pclk = 1'b0;
    logic             preset;
    logic [1:0]       req_valid, req_write;
    logic [1:0][15:0] req_addr, req_wdata;
    logic [1:0]       resp_done;
    logic [15:0]      resp_rdata;
    logic             resp_err, busy, psel, penable, pwrite;
    logic [15:0]      paddr, pwdata, prdata;
    logic             pready, pslverr;

    typedef struct {
        logic [1:0]  done;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    apb_arb_master #(.TIMEOUT(16)) dut (
        .pclk(pclk), .preset(preset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_done(resp_done),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy), .psel(psel),
        .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] d, input logic [15:0] r, input logic e);
        exp_t x;
        x.done = d; x.rdata = r; x.err = e;
        sb.push_back(x);
    endtask

    task automatic wait_done(input int max, output int cyc);
        cyc = 0;
        do begin
            @(negedge pclk);
            cyc++;
        end while (resp_done == 2'b00 && cyc < max);
        if (resp_done == 2'b00) chk("wait_done_timeout", 32'(resp_done), 32'h1);
    endtask

    // Monitor: every completion pulse must match the oldest outstanding expectation
    always @(negedge pclk) begin
        if (preset === 1'b1 && resp_done !== 2'b00) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(resp_done), 32'h0);
            end else begin
                mon_e = sb.pop_front();
                chk("done_idx", 32'(resp_done), 32'(mon_e.done));
                chk("rdata", 32'(resp_rdata), 32'(mon_e.rdata));
                chk("err", 32'(resp_err), 32'(mon_e.err));
            end
        end
    end

    initial begin
        int cyc, k, acc;
        int t[4];
        preset = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        prdata = '0; pready = 1'b1; pslverr = 1'b0;
        repeat (2) @(negedge pclk);
        chk("rst_psel", 32'(psel), 0);
        chk("rst_penable", 32'(penable), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_paddr", 32'(paddr), 0);
        chk("rst_done", 32'(resp_done), 0);
        preset = 1'b1;
        @(negedge pclk);

        // single write from requester 0
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 16'h0010; req_wdata[0] = 16'hBEEF;
        push(2'b01, 16'h0000, 1'b0);
        @(negedge pclk);
        chk("t1_setup_psel", 32'(psel), 1);
        chk("t1_setup_penable", 32'(penable), 0);
        chk("t1_paddr", 32'(paddr), 32'h0010);
        chk("t1_pwdata", 32'(pwdata), 32'hBEEF);
        chk("t1_pwrite", 32'(pwrite), 1);
        chk("t1_busy", 32'(busy), 1);
        @(negedge pclk);
        chk("t1_access_psel", 32'(psel), 1);
        chk("t1_access_penable", 32'(penable), 1);
        @(negedge pclk);
        chk("t1_done_at_3", 32'(resp_done), 32'h1);
        chk("t1_psel_off", 32'(psel), 0);
        req_valid = '0;
        @(negedge pclk);
        chk("t1_idle_busy", 32'(busy), 0);

        // read from requester 1 with two wait states
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 16'h0020; req_wdata[1] = 16'hAAAA;
        pready = 1'b0; prdata = 16'h1234;
        push(2'b10, 16'h1234, 1'b0);
        repeat (4) @(negedge pclk);
        chk("t2_stall_penable", 32'(penable), 1);
        chk("t2_pwdata_read", 32'(pwdata), 0);
        chk("t2_no_done_yet", 32'(resp_done), 0);
        pready = 1'b1;
        @(negedge pclk);
        chk("t2_done", 32'(resp_done), 32'h2);
        req_valid = '0;
        @(negedge pclk);

        // both held continuously: grants alternate 0,1,0,1
        req_write = 2'b01; req_addr[0] = 16'h0040; req_wdata[0] = 16'h1111;
        req_addr[1] = 16'h0050; prdata = 16'h5A5A;
        push(2'b01, 16'h0000, 1'b0); push(2'b10, 16'h5A5A, 1'b0);
        push(2'b01, 16'h0000, 1'b0); push(2'b10, 16'h5A5A, 1'b0);
        req_valid = 2'b11;
        k = 0; cyc = 0;
        while (k < 4 && cyc < 100) begin
            @(negedge pclk);
            cyc++;
            if (resp_done != 2'b00) begin t[k] = cyc; k++; end
        end
        req_valid = '0;
        chk("t3_done_count", 32'(k), 4);
        chk("t3_first_latency", 32'(t[0]), 3);
        chk("t3_period", 32'(t[1] - t[0]), 4);
        @(negedge pclk);

        // timeout: pready never rises
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 16'h0030;
        pready = 1'b0; prdata = 16'hFFFF;
        push(2'b01, 16'h0000, 1'b1);
        acc = 0; cyc = 0;
        do begin
            @(negedge pclk);
            cyc++;
            if (psel && penable) acc++;
        end while (resp_done == 2'b00 && cyc < 100);
        chk("t4_access_cycles", 32'(acc), 16);
        chk("t4_psel_off", 32'(psel), 0);
        req_valid = '0; pready = 1'b1;
        @(negedge pclk);

        // slave error on a write
        req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 16'h0060; req_wdata[1] = 16'hCAFE;
        pslverr = 1'b1;
        push(2'b10, 16'h0000, 1'b1);
        wait_done(20, cyc);
        chk("t5_latency", 32'(cyc), 3);
        req_valid = '0; pslverr = 1'b0;
        @(negedge pclk);

        // reset during ACCESS aborts without a completion
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 16'h0070; pready = 1'b0;
        repeat (2) @(negedge pclk);
        chk("t6_in_access", 32'(penable), 1);
        #2 preset = 1'b0;
        #1;
        chk("t6_psel_async", 32'(psel), 0);
        chk("t6_penable_async", 32'(penable), 0);
        chk("t6_busy_async", 32'(busy), 0);
        chk("t6_paddr_async", 32'(paddr), 0);
        req_valid = '0; pready = 1'b1;
        repeat (2) @(negedge pclk);
        chk("t6_no_done", 32'(resp_done), 0);
        preset = 1'b1;

        // first tie after reset goes to requester 0
        req_valid = 2'b11; req_write = 2'b00; prdata = 16'h7777;
        push(2'b01, 16'h7777, 1'b0);
        wait_done(20, cyc);
        chk("t7_tie_winner", 32'(resp_done), 32'h1);
        req_valid = '0;
        repeat (3) @(negedge pclk);
        chk("sb_empty", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
